// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   NOP_INSTR   : instruction presented to decode when the queue head is empty
//   ifq_entry_t : one queue slot {pc, data, filled}
package ifetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        filled;
    } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF->ID register.
// Issues sequential word-aligned fetches, buffers in-order responses tagged with
// their PCs and hands them to decode over a valid/ready handshake. A redirect
// from EX flushes the queue, restarts fetch at the target and discards every
// response still in flight for the old stream before any new request goes out.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req_valid    out  fetch request valid
//   req_ready    in   imem accepts the request this cycle
//   req_addr     out  fetch address (word aligned)
//   resp_valid   in   imem response valid, in request order
//   resp_data    in   fetched instruction word
//   instr_valid  out  head entry holds a fetched instruction
//   instr_ready  in   decode consumes the head this cycle
//   instr        out  head instruction, NOP when !instr_valid
//   instr_pc     out  head PC, 0 when !instr_valid
//   redirect     in   taken branch/jump: flush and restart
//   redirect_pc  in   restart address, low two bits ignored
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ifq_entry_t       entries [DEPTH];
    ifq_entry_t       head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occ;       // allocated entries, filled or not
    logic [CNT_W-1:0] pend;      // allocated entries still waiting for data
    logic [CNT_W-1:0] drop_cnt;  // stale responses still to be discarded
    logic [31:0]      fetch_pc;

    logic alloc;
    logic fill_en;
    logic drop_en;
    logic pop;

    assign head_entry = entries[head];

    // Requests are held off while reset is asserted so the port reads idle
    // immediately, without waiting for a clock edge.
    assign req_valid = reset && !redirect && (occ < CNT_W'(DEPTH)) && (drop_cnt == '0);
    assign req_addr  = fetch_pc;

    assign instr_valid = head_entry.filled;
    assign instr       = head_entry.filled ? head_entry.data : NOP_INSTR;
    assign instr_pc    = head_entry.filled ? head_entry.pc   : 32'h0;

    // req_valid already excludes redirect cycles.
    assign alloc   = req_valid && req_ready;
    assign drop_en = resp_valid && (drop_cnt != '0);
    assign fill_en = resp_valid && (drop_cnt == '0) && !redirect;
    assign pop     = instr_valid && instr_ready && !redirect;

    // Alloc targets a free slot, fill an allocated-unfilled slot and pop a
    // filled slot, so the three writes never collide on one entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            occ      <= '0;
            pend     <= '0;
            drop_cnt <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            occ      <= '0;
            pend     <= '0;
            fetch_pc <= redirect_pc & ~32'h3;
            // Everything still in flight is stale; a response arriving right
            // now is discarded as well, so it no longer needs dropping later.
            drop_cnt <= drop_cnt + pend - CNT_W'(resp_valid);
        end else begin
            if (alloc) begin
                entries[tail] <= '{pc: fetch_pc, data: 32'h0, filled: 1'b0};
                tail          <= tail + PTR_W'(1);
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (fill_en) begin
                entries[fill].data   <= resp_data;
                entries[fill].filled <= 1'b1;
                fill                 <= fill + PTR_W'(1);
            end
            if (pop) begin
                entries[head].filled <= 1'b0;
                head                 <= head + PTR_W'(1);
            end
            if (drop_en) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            occ  <= occ + CNT_W'(alloc) - CNT_W'(pop);
            pend <= pend + CNT_W'(alloc) - CNT_W'(fill_en);
        end
    end

    // imem must never answer a request that was not made.
    resp_has_request: assert property (@(posedge clk) disable iff (!reset)
        resp_valid |-> ((pend != '0) || (drop_cnt != '0)));

endmodule
